ones_count_ctrl: RTL and testbench
==================================

# ones_count_ctrl

Arbitrating sequencer for the SDR-bank ones-count datapath. Several requesters each ask for the total number of set bits over a window of consecutive words of the 32x32 SDR register bank. The block grants one requester at a time, round-robin. It walks the window one word per cycle through a read port into the bank, accumulates the per-word popcount, and returns the total on a valid/ready response channel tagged with the requester index.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- NUM_WORDS, 32, words in the SDR bank (power of two)
- WORD_W, 32, bits per bank word
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous active-high reset
- req_i  in  NUM_REQ  per-requester request level
- req_start_i  in  NUM_REQ x log2(NUM_WORDS)  first word index of window
- req_len_i  in  NUM_REQ x (log2(NUM_WORDS)+1)  window length in words
- gnt_o  out  NUM_REQ  one-hot, one-cycle grant pulse
- busy_o  out  1  high from grant until response accepted
- rd_addr_o  out  log2(NUM_WORDS)  bank word address
- rd_data_i  in  WORD_W  bank word, combinational read of rd_addr_o
- rsp_valid_o  out  1  result available
- rsp_ready_i  in  1  consumer accepts result
- rsp_id_o  out  log2(NUM_REQ)  granted requester index
- rsp_count_o  out  log2(NUM_WORDS*WORD_W)+1  total ones in window

## Operation
- FSM states: IDLE, COUNT, RESP. Reset state is IDLE.
- IDLE:
  - If any req_i is set, select a requester round-robin. Priority starts at the requester after the last granted one. After reset, requester 0 has top priority.
  - On the clock edge: pulse gnt_o for the winner, latch its start, clamped length and id, clear the accumulator, and set the remaining-word counter.
  - Go to COUNT if the length is nonzero, otherwise go to RESP.
- Length rules: req_len_i of 0 gives an empty window and a count of 0. req_len_i greater than NUM_WORDS is clamped to NUM_WORDS.
- COUNT:
  - rd_addr_o = (start + word index) mod NUM_WORDS, so the window wraps past the last word to word 0.
  - Each cycle, add popcount(rd_data_i) to the accumulator and decrement the remaining-word counter.
  - After the last word, go to RESP.
- RESP:
  - rsp_valid_o is high. rsp_id_o and rsp_count_o hold stable until rsp_valid_o && rsp_ready_i.
  - When the response is accepted, go to IDLE and store the granted id as the round-robin pointer.
- Requester obligations:
  - A requester holds req_i, start and len stable until it sees its gnt_o.
  - A request dropped before grant is never served.
  - req_i changes outside IDLE are ignored.
- Accumulator width is log2(NUM_WORDS*WORD_W)+1 bits (11 at defaults), so no overflow is possible.
- Bank contents are sampled live. A bank word changing during COUNT affects the result only if its address has not yet been read.

## Timing
- Reset values: gnt_o=0, busy_o=0, rd_addr_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_count_o=0, round-robin pointer = NUM_REQ-1.
- Grant latency: req_i sampled high in IDLE at edge E gives gnt_o high for the cycle after E.
- COUNT lasts exactly L cycles, where L is the clamped length.
- rsp_valid_o rises L+1 cycles after E (1 cycle when L=0).
- A new grant can be issued no earlier than the cycle after response acceptance, so there is one IDLE cycle minimum between jobs.
- busy_o is high from the gnt_o cycle through the acceptance cycle.
- rst_i asserted mid-job aborts immediately: no response is issued, and all outputs and the pointer return to reset values.

## Configuration
- ONES_COUNT_CTRL_THRESH_EN defined:
  - Adds input thresh_i (same width as rsp_count_o) and output rsp_over_o.
  - rsp_over_o = (rsp_count_o > thresh_i), computed from thresh_i latched at grant.
  - rsp_over_o is valid with rsp_valid_o and is 0 at reset.
- Not defined: thresh_i and rsp_over_o do not exist, and all other behaviour is identical.

## Test plan
- Single job: bank all-ones, req_i[0], start=0, len=32 -> gnt_o[0] pulse, 32 COUNT cycles, rsp_count_o=1024, rsp_id_o=0.
- Wrap and length rules:
  - Word k holds k ones; start=30, len=4 -> addresses 30,31,0,1 in order, count=62.
  - len=0 -> rsp_valid_o one cycle after grant, count=0.
  - len=40 -> clamped to 32 words.
- Round-robin: req_i=2'b11 held continuously, instant ready -> grants alternate 0,1,0,1. After reset the first grant goes to 0.
- Backpressure: rsp_ready_i low for 5 cycles in RESP -> rsp_valid_o, rsp_id_o and rsp_count_o stable, no new gnt_o while req_i[1] is pending, grant follows acceptance by one cycle.
- Reset mid-COUNT: assert rst_i at word 10 -> all outputs 0 at once, no rsp_valid_o. A fresh request then completes normally with the correct count.
- THRESH_EN build:
  - thresh_i=100, window count 101 -> rsp_over_o=1.
  - Same window with thresh_i=101 -> rsp_over_o=0.

Source files
------------

// File: rtl/ones_count_ctrl.sv
// Round-robin sequencer that counts set bits over a wrapping window of the SDR bank.
// Define ONES_COUNT_CTRL_THRESH_EN to add thresh_i / rsp_over_o threshold flagging.
module ones_count_ctrl #(
  parameter int NUM_REQ   = 2,
  parameter int NUM_WORDS = 32,
  parameter int WORD_W    = 32,
  localparam int AW = $clog2(NUM_WORDS),
  localparam int LW = AW + 1,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(NUM_WORDS * WORD_W) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*AW-1:0] req_start_i,
  input  logic [NUM_REQ*LW-1:0] req_len_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic                  busy_o,
  output logic [AW-1:0]         rd_addr_o,
  input  logic [WORD_W-1:0]     rd_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IW-1:0]         rsp_id_o,
  output logic [CW-1:0]         rsp_count_o
`ifdef ONES_COUNT_CTRL_THRESH_EN
  ,
  input  logic [CW-1:0]         thresh_i,
  output logic                  rsp_over_o
`endif
);

  localparam int PW = $clog2(WORD_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_RESP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [NUM_REQ-1:0] r_gnt;
  logic [AW-1:0]      r_addr;
  logic [LW-1:0]      r_remain;
  logic [IW-1:0]      r_id;
  logic [CW-1:0]      r_acc;
  logic [IW-1:0]      r_rr_ptr;

  logic [AW-1:0]      w_start     [NUM_REQ];
  logic [LW-1:0]      w_len_clamp [NUM_REQ];
  logic [IW-1:0]      w_rot_idx   [NUM_REQ];
  logic [NUM_REQ-1:0] w_rot_req;
  logic               w_any;
  logic [IW-1:0]      w_win;
  logic               w_grant;
  logic               w_accept;
  logic [PW-1:0]      w_pop;

  // Slot gi of the rotated view is the requester gi+1 places after the pointer.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic [LW-1:0] w_len_raw;
    assign w_start[gi]     = req_start_i[gi*AW +: AW];
    assign w_len_raw       = req_len_i[gi*LW +: LW];
    assign w_len_clamp[gi] = (w_len_raw > LW'(NUM_WORDS)) ? LW'(NUM_WORDS) : w_len_raw;
    assign w_rot_idx[gi]   = IW'((int'(r_rr_ptr) + gi + 1) % NUM_REQ);
    assign w_rot_req[gi]   = req_i[w_rot_idx[gi]];
  end

  assign w_any = |w_rot_req;

  always_comb begin
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot_req[k]) begin
        w_win = w_rot_idx[k];
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int b = 0; b < WORD_W; b++) begin
      w_pop = w_pop + PW'(rd_data_i[b]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_accept     = 1'b0;
    busy_o       = 1'b0;
    rsp_valid_o  = 1'b0;
    rd_addr_o    = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant      = 1'b1;
          w_state_next = (w_len_clamp[w_win] == '0) ? ST_RESP : ST_COUNT;
        end
      end
      ST_COUNT: begin
        busy_o    = 1'b1;
        rd_addr_o = r_addr;
        if (r_remain == LW'(1)) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        busy_o      = 1'b1;
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          w_accept     = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gnt    <= '0;
      r_addr   <= '0;
      r_remain <= '0;
      r_id     <= '0;
      r_acc    <= '0;
      r_rr_ptr <= IW'(NUM_REQ - 1);
    end else begin
      r_gnt <= '0;
      if (w_grant) begin
        r_gnt    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
        r_addr   <= w_start[w_win];
        r_remain <= w_len_clamp[w_win];
        r_id     <= w_win;
        r_acc    <= '0;
      end
      // The address counter is AW bits wide, so the window wraps to word 0 for free.
      if (r_state == ST_COUNT) begin
        r_acc    <= r_acc + CW'(w_pop);
        r_addr   <= r_addr + 1'b1;
        r_remain <= r_remain - 1'b1;
      end
      if (w_accept) begin
        r_rr_ptr <= r_id;
      end
    end
  end

  assign gnt_o       = r_gnt;
  assign rsp_id_o    = r_id;
  assign rsp_count_o = r_acc;

`ifdef ONES_COUNT_CTRL_THRESH_EN
  logic [CW-1:0] r_thresh;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_thresh <= '0;
    end else if (w_grant) begin
      r_thresh <= thresh_i;
    end
  end

  assign rsp_over_o = (r_state == ST_RESP) && (r_acc > r_thresh);
`endif

endmodule

// File: tb/tb_ones_count_ctrl.sv
// Directed bench for ones_count_ctrl: window counting, wrap/clamp, round-robin,
// backpressure and mid-job reset, plus threshold cases when that build is enabled.
module tb_ones_count_ctrl;
  localparam int NR = 2;
  localparam int NW = 32;
  localparam int WW = 32;
  localparam int AW = 5;
  localparam int LW = 6;
  localparam int IW = 1;
  localparam int CW = 11;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_start;
  logic [NR*LW-1:0] req_len;
  logic [NR-1:0]    gnt;
  logic             busy;
  logic [AW-1:0]    rd_addr;
  logic [WW-1:0]    rd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IW-1:0]    rsp_id;
  logic [CW-1:0]    rsp_count;
`ifdef ONES_COUNT_CTRL_THRESH_EN
  logic [CW-1:0]    thresh;
  logic             rsp_over;
`endif

  logic [WW-1:0] bank [NW];
  int n_checks = 0;
  int n_fail   = 0;

  assign rd_data = bank[rd_addr];

  ones_count_ctrl #(.NUM_REQ(NR), .NUM_WORDS(NW), .WORD_W(WW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .req_start_i (req_start),
    .req_len_i   (req_len),
    .gnt_o       (gnt),
    .busy_o      (busy),
    .rd_addr_o   (rd_addr),
    .rd_data_i   (rd_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_count_o (rsp_count)
`ifdef ONES_COUNT_CTRL_THRESH_EN
    ,
    .thresh_i    (thresh),
    .rsp_over_o  (rsp_over)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input int start, input int len);
    req_start[id*AW +: AW] = AW'(start);
    req_len[id*LW +: LW]   = LW'(len);
    req[id]                = 1'b1;
  endtask

  task automatic wait_gnt(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (gnt != '0) seen = 1'b1;
    end
    check("gnt_seen", 32'(seen), 32'd1);
  endtask

  task automatic finish_job(input int exp_id, input int exp_count);
    int n;
    n = 0;
    while (!rsp_valid && n < 64) begin
      tick();
      n++;
    end
    check("fin_valid", 32'(rsp_valid), 32'd1);
    check("fin_id", 32'(rsp_id), 32'(exp_id));
    check("fin_count", 32'(rsp_count), 32'(exp_count));
    $display("job id=%0d count=%0d", rsp_id, rsp_count);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic kones_bank();
    for (int k = 0; k < NW; k++) bank[k] = (k == 0) ? 32'd0 : (32'hFFFF_FFFF >> (32 - k));
  endtask

  task automatic run_job(input int id, input int start, input int len, input int exp_count);
    int  exp_len;
    int  n;
    bit  seen;
    exp_len = (len > NW) ? NW : len;
    set_req(id, start, len);
    wait_gnt(seen);
    check("gnt_onehot", 32'(gnt), 32'd1 << id);
    check("busy_at_gnt", 32'(busy), 32'd1);
    req[id] = 1'b0;
    n = 0;
    while (!rsp_valid && n < 64) begin
      check("rd_addr", 32'(rd_addr), 32'((start + n) % NW));
      tick();
      n++;
    end
    check("count_cycles", 32'(n), 32'(exp_len));
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("rsp_count", 32'(rsp_count), 32'(exp_count));
`ifdef ONES_COUNT_CTRL_THRESH_EN
    check("rsp_over", 32'(rsp_over), (exp_count > int'(thresh)) ? 32'd1 : 32'd0);
`endif
    $display("job id=%0d start=%0d len=%0d cycles=%0d count=%0d", id, start, len, n, rsp_count);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("valid_after_accept", 32'(rsp_valid), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bit seen;
    int grants [4];
    int gcyc [4];
    int ng;
    int saw_valid;
    req       = '0;
    req_start = '0;
    req_len   = '0;
    rsp_ready = 1'b0;
`ifdef ONES_COUNT_CTRL_THRESH_EN
    thresh    = '0;
`endif
    for (int k = 0; k < NW; k++) bank[k] = 32'hFFFF_FFFF;
    rst = 1'b1;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_count", 32'(rsp_count), 32'd0);
    rst = 1'b0;
    tick();

    // Full bank of ones.
    run_job(0, 0, 32, 1024);

    // Window, wrap and length rules on a bank where word k has k ones.
    kones_bank();
    run_job(1, 30, 4, 62);
    run_job(0, 7, 0, 0);
    run_job(1, 5, 40, 496);
    run_job(0, 3, 5, 25);

    // Round-robin with both requesting and instant ready.
    do_reset();
    set_req(0, 3, 1);
    set_req(1, 7, 1);
    rsp_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      tick();
      if (rsp_valid) check("rr_count", 32'(rsp_count), (rsp_id == 1'b1) ? 32'd7 : 32'd3);
      if (gnt != '0) begin
        grants[ng] = int'(gnt);
        gcyc[ng]   = c;
        $display("rr grant #%0d gnt=%b cycle=%0d", ng, gnt, c);
        ng++;
      end
    end
    req = '0;
    check("rr_ngrants", 32'(ng), 32'd4);
    check("rr_g0", 32'(grants[0]), 32'd1);
    check("rr_g1", 32'(grants[1]), 32'd2);
    check("rr_g2", 32'(grants[2]), 32'd1);
    check("rr_g3", 32'(grants[3]), 32'd2);
    check("rr_spacing", 32'(gcyc[2] - gcyc[1]), 32'd3);
    repeat (4) tick();
    rsp_ready = 1'b0;

    // Backpressure: response held while requester 1 waits.
    do_reset();
    set_req(0, 4, 2);
    wait_gnt(seen);
    check("bp_gnt0", 32'(gnt), 32'd1);
    req[0] = 1'b0;
    set_req(1, 20, 1);
    for (int c = 0; c < 10 && !rsp_valid; c++) tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd0);
      check("bp_count", 32'(rsp_count), 32'd9);
      check("bp_no_gnt", 32'(gnt), 32'd0);
      tick();
    end
    $display("bp job id=%0d count=%0d held 5 cycles", rsp_id, rsp_count);
    rsp_ready = 1'b1;
    check("bp_valid_acc", 32'(rsp_valid), 32'd1);
    tick();
    rsp_ready = 1'b0;
    check("bp_idle_gnt", 32'(gnt), 32'd0);
    check("bp_idle_busy", 32'(busy), 32'd0);
    tick();
    check("bp_gnt1", 32'(gnt), 32'd2);
    req[1] = 1'b0;
    finish_job(1, 20);

    // Leave the pointer at 0, then abort a job from requester 1 mid-window.
    run_job(0, 3, 5, 25);
    set_req(1, 0, 32);
    wait_gnt(seen);
    req[1] = 1'b0;
    for (int c = 0; c < 20 && rd_addr != AW'(10); c++) tick();
    check("mid_addr", 32'(rd_addr), 32'd10);
    rst = 1'b1;
    #1;
    check("mr_gnt", 32'(gnt), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_rd_addr", 32'(rd_addr), 32'd0);
    check("mr_valid", 32'(rsp_valid), 32'd0);
    check("mr_id", 32'(rsp_id), 32'd0);
    check("mr_count", 32'(rsp_count), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    saw_valid = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (rsp_valid) saw_valid++;
    end
    check("mr_no_rsp", 32'(saw_valid), 32'd0);

    // After reset requester 0 again has top priority.
    set_req(0, 10, 3);
    set_req(1, 1, 2);
    wait_gnt(seen);
    check("ptr_after_reset", 32'(gnt), 32'd1);
    req[0] = 1'b0;
    finish_job(0, 33);
    run_job(1, 1, 2, 3);

`ifdef ONES_COUNT_CTRL_THRESH_EN
    bank[0] = 32'hFFFF_FFFF;
    bank[1] = 32'hFFFF_FFFF;
    bank[2] = 32'hFFFF_FFFF;
    bank[3] = 32'h0000_001F;
    thresh = CW'(100);
    run_job(0, 0, 4, 101);
    thresh = CW'(101);
    run_job(1, 0, 4, 101);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
